// File: rtl/instr_exec_unit.sv
// Instruction execute unit: pops 12-bit words from the queue, runs them on an 8-entry regfile.
// Optional shift-add multiplier built when IEU_MUL_EN is defined; otherwise opcode 110 is a NOP.
module instr_exec_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [11:0]       q_instr,
    input  logic              q_empty,
    output logic              q_dequeue,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        retire_cnt,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CW = $clog2(DATA_W);

`ifdef IEU_MUL_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MUL   = 2'd2,
        S_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd3
    } state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [11:0]       r_instr;
    logic [DATA_W-1:0] r_regs [8];
    logic [7:0]        r_retire;

    logic [2:0]        w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic [5:0]        w_imm;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_retire;
    logic              w_mul_start;

    assign w_op     = r_instr[11:9];
    assign w_rd     = r_instr[8:6];
    assign w_rs     = r_instr[5:3];
    assign w_rt     = r_instr[2:0];
    assign w_imm    = r_instr[5:0];
    assign w_rs_val = r_regs[w_rs];
    assign w_rt_val = r_regs[w_rt];

`ifdef IEU_MUL_EN
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CW-1:0]     r_bitcnt;
    logic [DATA_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        q_dequeue   = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = '0;
        w_retire    = 1'b0;
        w_mul_start = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (run && !q_empty) begin
                    q_dequeue = 1'b1;
                    w_next    = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_FETCH;
                unique case (w_op)
                    3'b000: w_retire = 1'b1;
                    3'b001: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_rs_val + w_rt_val;
                        w_retire  = 1'b1;
                    end
                    3'b010: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_rs_val - w_rt_val;
                        w_retire  = 1'b1;
                    end
                    3'b011: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_rs_val & w_rt_val;
                        w_retire  = 1'b1;
                    end
                    3'b100: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_rs_val ^ w_rt_val;
                        w_retire  = 1'b1;
                    end
                    3'b101: begin
                        w_wr_en   = 1'b1;
                        w_wr_data = DATA_W'(w_imm);
                        w_retire  = 1'b1;
                    end
                    3'b110: begin
`ifdef IEU_MUL_EN
                        w_mul_start = 1'b1;
                        w_next      = S_MUL;
`else
                        w_retire = 1'b1;
`endif
                    end
                    3'b111: begin
                        w_retire = 1'b1;
                        w_next   = S_HALT;
                    end
                endcase
            end
`ifdef IEU_MUL_EN
            S_MUL: begin
                // Final bit folds straight into the writeback.
                if (r_bitcnt == CW'(DATA_W - 1)) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_acc_next;
                    w_retire  = 1'b1;
                    w_next    = S_FETCH;
                end
            end
`endif
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr  <= '0;
            r_retire <= '0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (q_dequeue) begin
                r_instr <= q_instr;
            end
            if (w_retire) begin
                r_retire <= r_retire + 8'd1;
            end
            if (w_wr_en && (w_rd != 3'd0)) begin
                r_regs[w_rd] <= w_wr_data;
            end
        end
    end

`ifdef IEU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_bitcnt <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= w_rs_val;
            r_mplier <= w_rt_val;
            r_acc    <= '0;
            r_bitcnt <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    assign busy = (r_state == S_EXEC) || (r_state == S_MUL);
`else
    assign busy = (r_state == S_EXEC);
`endif

    assign halted     = (r_state == S_HALT);
    assign retire_cnt = r_retire;
    assign dbg_data   = (dbg_sel == 3'd0) ? '0 : r_regs[dbg_sel];

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit with a simple array-backed queue model.
// Expected values adapt to whether IEU_MUL_EN is defined.
module tb_instr_exec_unit;

    localparam int DW = 8;

`ifdef IEU_MUL_EN
    localparam logic [7:0] EXP_R4 = 8'h23;
    localparam logic [7:0] EXP_R6 = 8'h04;
    localparam logic [7:0] EXP_R7 = 8'h0E;
    localparam logic [7:0] EXP_R3 = 8'h23;
    localparam int         EXP_BUSY = 9;
    localparam logic       EXP_MID_BUSY = 1'b1;
`else
    localparam logic [7:0] EXP_R4 = 8'h00;
    localparam logic [7:0] EXP_R6 = 8'h05;
    localparam logic [7:0] EXP_R7 = 8'h02;
    localparam logic [7:0] EXP_R3 = 8'h0C;
    localparam int         EXP_BUSY = 1;
    localparam logic       EXP_MID_BUSY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [11:0]   q_instr;
    logic          q_empty;
    logic          q_dequeue;
    logic          busy;
    logic          halted;
    logic [7:0]    retire_cnt;
    logic [2:0]    dbg_sel = 3'd0;
    logic [DW-1:0] dbg_data;

    logic [11:0] mem [64];
    int head = 0;
    int tail = 0;
    int pop_cnt = 0;
    int checks = 0;
    int errors = 0;

    assign q_instr = mem[head[5:0]];
    assign q_empty = (head == tail);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (q_dequeue) begin
            head    <= head + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    instr_exec_unit #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .q_instr    (q_instr),
        .q_empty    (q_empty),
        .q_dequeue  (q_dequeue),
        .busy       (busy),
        .halted     (halted),
        .retire_cnt (retire_cnt),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    task automatic push(input logic [11:0] w);
        mem[tail[5:0]] = w;
        tail = tail + 1;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (head == tail && busy == 1'b0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles (head=%0d tail=%0d)",
                     budget, head, tail);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        run = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (retire_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_retire: got %0d want 0", retire_cnt);
        end
        checks++;
        if ({busy, halted, q_dequeue} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b want 000", {busy, halted, q_dequeue});
        end
        for (int r = 0; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg r%0d: got %h want 00", r, dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ldi;
        push(12'hA45);
        push(12'hA87);
        #1;
        checks++;
        if (q_dequeue !== 1'b1) begin
            errors++;
            $display("FAIL ldi_pop1: got %b want 1", q_dequeue);
        end
        @(negedge clk);
        dbg_sel = 3'd1;
        #1;
        checks++;
        if ({busy, q_dequeue, dbg_data} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL ldi_exec_cycle: got busy=%b deq=%b r1=%h want 1 0 00",
                     busy, q_dequeue, dbg_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, q_dequeue, dbg_data} !== {2'b01, 8'h05}) begin
            errors++;
            $display("FAIL ldi_writeback: got busy=%b deq=%b r1=%h want 0 1 05",
                     busy, q_dequeue, dbg_data);
        end
        wait_idle(20);
        dbg_sel = 3'd2;
        #1;
        checks++;
        if (dbg_data !== 8'h07) begin
            errors++;
            $display("FAIL ldi_r2: got %h want 07", dbg_data);
        end
        checks++;
        if (retire_cnt !== 8'd2 || pop_cnt != 2) begin
            errors++;
            $display("FAIL ldi_counts: got retire=%0d pops=%0d want 2 2", retire_cnt, pop_cnt);
        end
    endtask

    task automatic test_alu;
        push(12'h2CA);
        push(12'h54A);
        push(12'h78A);
        push(12'h9CA);
        push(12'h000);
        wait_idle(40);
        dbg_sel = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 8'h0C) begin
            errors++;
            $display("FAIL alu_add: got %h want 0C", dbg_data);
        end
        dbg_sel = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 8'hFE) begin
            errors++;
            $display("FAIL alu_sub_wrap: got %h want FE", dbg_data);
        end
        dbg_sel = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 8'h05) begin
            errors++;
            $display("FAIL alu_and: got %h want 05", dbg_data);
        end
        dbg_sel = 3'd7;
        #1;
        checks++;
        if (dbg_data !== 8'h02) begin
            errors++;
            $display("FAIL alu_xor: got %h want 02", dbg_data);
        end
        checks++;
        if (retire_cnt !== 8'd7) begin
            errors++;
            $display("FAIL alu_retire: got %0d want 7", retire_cnt);
        end
    endtask

    task automatic test_mul;
        int nb;
        nb = 0;
        push(12'hD0A);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (busy) nb++;
        end
        checks++;
        if (nb != EXP_BUSY) begin
            errors++;
            $display("FAIL mul_busy_cycles: got %0d want %0d", nb, EXP_BUSY);
        end
        dbg_sel = 3'd4;
        #1;
        checks++;
        if (dbg_data !== EXP_R4) begin
            errors++;
            $display("FAIL mul_r4: got %h want %h", dbg_data, EXP_R4);
        end
        checks++;
        if (retire_cnt !== 8'd8) begin
            errors++;
            $display("FAIL mul_retire: got %0d want 8", retire_cnt);
        end
        push(12'hDAD);
        push(12'hDFA);
        wait_idle(60);
        dbg_sel = 3'd6;
        #1;
        checks++;
        if (dbg_data !== EXP_R6) begin
            errors++;
            $display("FAIL mul_overflow_r6: got %h want %h", dbg_data, EXP_R6);
        end
        dbg_sel = 3'd7;
        #1;
        checks++;
        if (dbg_data !== EXP_R7) begin
            errors++;
            $display("FAIL mul_rd_eq_rs_r7: got %h want %h", dbg_data, EXP_R7);
        end
        dbg_sel = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 8'hFE || retire_cnt !== 8'd10) begin
            errors++;
            $display("FAIL mul_side: got r5=%h retire=%0d want FE 10", dbg_data, retire_cnt);
        end
    endtask

    task automatic test_r0;
        push(12'hA3F);
        wait_idle(20);
        dbg_sel = 3'd0;
        #1;
        checks++;
        if (dbg_data !== 8'h00 || retire_cnt !== 8'd11) begin
            errors++;
            $display("FAIL r0_write: got r0=%h retire=%0d want 00 11", dbg_data, retire_cnt);
        end
    endtask

    task automatic test_stall_run;
        int bad;
        int pc;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (q_dequeue !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_empty: got %0d bad cycles want 0", bad);
        end
        push(12'hCCA);
        @(negedge clk);
        run = 1'b0;
        push(12'h000);
        pc = pop_cnt;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            #1;
            if (q_dequeue !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || pop_cnt != pc) begin
            errors++;
            $display("FAIL run_low_pop: got %0d deq cycles, pops %0d want 0, %0d", bad, pop_cnt, pc);
        end
        dbg_sel = 3'd3;
        #1;
        checks++;
        if (dbg_data !== EXP_R3 || busy !== 1'b0 || retire_cnt !== 8'd12) begin
            errors++;
            $display("FAIL run_low_inflight: got r3=%h busy=%b retire=%0d want %h 0 12",
                     dbg_data, busy, retire_cnt, EXP_R3);
        end
        run = 1'b1;
        wait_idle(20);
        checks++;
        if (retire_cnt !== 8'd13) begin
            errors++;
            $display("FAIL run_resume: got %0d want 13", retire_cnt);
        end
    endtask

    task automatic test_halt;
        int pc;
        int bad;
        bit seen;
        pc = pop_cnt;
        seen = 0;
        bad = 0;
        push(12'hE00);
        push(12'hA7F);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (halted) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL halt_enter: got halted=%b want 1", halted);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (q_dequeue !== 1'b0 || busy !== 1'b0 || halted !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || pop_cnt != pc + 1) begin
            errors++;
            $display("FAIL halt_frozen: got bad=%0d pops=%0d want 0 %0d", bad, pop_cnt, pc + 1);
        end
        dbg_sel = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 8'h05 || retire_cnt !== 8'd14) begin
            errors++;
            $display("FAIL halt_state: got r1=%h retire=%0d want 05 14", dbg_data, retire_cnt);
        end
    endtask

    task automatic test_reset_mid_mul;
        int pc;
        int bad;
        @(negedge clk);
        rst_n = 1'b0;
        tail = head;
        #1;
        checks++;
        if (halted !== 1'b0 || retire_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got halted=%b retire=%0d want 0 0", halted, retire_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pc = pop_cnt;
        push(12'hA45);
        push(12'hA87);
        push(12'hD0A);
        bad = 1;
        for (int i = 0; i < 30 && bad != 0; i++) begin
            @(negedge clk);
            #1;
            if (pop_cnt == pc + 3) bad = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bad != 0 || busy !== EXP_MID_BUSY) begin
            errors++;
            $display("FAIL mid_mul_setup: got busy=%b pops=%0d want %b %0d",
                     busy, pop_cnt - pc, EXP_MID_BUSY, 3);
        end
        rst_n = 1'b0;
        #1;
        bad = 0;
        for (int r = 0; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1;
            if (dbg_data !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0 || retire_cnt !== 8'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL mid_mul_reset: got nonzero_regs=%0d retire=%0d busy=%b want 0 0 0",
                     bad, retire_cnt, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pc = pop_cnt;
        repeat (12) @(negedge clk);
        dbg_sel = 3'd4;
        #1;
        checks++;
        if (dbg_data !== 8'h00 || retire_cnt !== 8'd0 || pop_cnt != pc) begin
            errors++;
            $display("FAIL mid_mul_no_wb: got r4=%h retire=%0d pops=%0d want 00 0 %0d",
                     dbg_data, retire_cnt, pop_cnt, pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 12'h000;
        test_reset;
        test_ldi;
        test_alu;
        test_mul;
        test_r0;
        test_stall_run;
        test_halt;
        test_reset_mid_mul;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
Downstream consumer of the 8-entry instruction queue. Pops 12-bit instructions when the queue is non-empty and decodes them. Executes them against an 8-entry register file, with single-cycle ALU ops and a multi-cycle shift-add multiply. Exposes a debug read port, a retire counter and busy/halted status to the top level.

Parameters:
DATA_W, 8, register/datapath width in bits; must be >= 6 so the LDI immediate fits.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
run  input  1  execution enable; FETCH pops only while high
q_instr  input  12  queue head word; combinational from queue, valid when q_empty=0
q_empty  input  1  queue empty flag
q_dequeue  output  1  pop strobe to queue; combinational
busy  output  1  high in EXEC or MUL state
halted  output  1  high in HALT state
retire_cnt  output  8  count of retired instructions, wraps 255->0
dbg_sel  input  3  register index for debug read
dbg_data  output  DATA_W  combinational read of regs[dbg_sel]; r0 always reads 0

Behaviour:
- Reset: state=FETCH; all regs 0; instr_r=0; retire_cnt=0; MUL datapath cleared; busy=0, halted=0, q_dequeue=0. Async reset mid-MUL aborts the multiply, with no writeback.
- Instruction format: [11:9] opcode, [8:6] rd, [5:3] rs, [2:0] rt; imm6=[5:0].
- Opcodes:
  - 000 NOP.
  - 001 ADD rd=rs+rt.
  - 010 SUB rd=rs-rt.
  - 011 AND.
  - 100 XOR.
  - 101 LDI rd=zero-extended imm6.
  - 110 MUL rd=low DATA_W bits of rs*rt.
  - 111 HALT.
- All arithmetic is modulo 2^DATA_W; no flags.
- r0 is hardwired to 0; writes with rd=0 are discarded but the instruction still retires.
- FETCH: q_dequeue = run && !q_empty (only in FETCH). When asserted, instr_r<=q_instr and the next state is EXEC. Otherwise hold. q_dequeue is never asserted in any other state, so one pop equals exactly one instruction.
- EXEC:
  - Opcodes 000-101: write rd, retire_cnt++, ->FETCH.
  - Opcode 110: latch rs into the multiplicand and rt into the multiplier, clear acc and the bit counter, ->MUL.
  - Opcode 111: retire_cnt++, ->HALT.
- MUL: one multiplier bit per cycle, LSB first. If the bit is 1, acc+=mcand. Then mcand<<=1, mplier>>=1.
  - After DATA_W cycles: write acc to rd, retire_cnt++, ->FETCH.
  - Operands are sampled once in EXEC, so rd==rs or rd==rt is safe.
- HALT: terminal. q_dequeue=0; regs and retire_cnt are frozen until reset. run is ignored.
- Latency, from the FETCH pop cycle to the register-file update edge:
  - ALU/LDI: 2 cycles (pop edge plus EXEC edge).
  - MUL: 2+DATA_W cycles.
  - Back-to-back ALU ops retire every 2 cycles.
- run low: blocks only new pops. An instruction already in EXEC or MUL completes.
- q_empty=1 in FETCH: stall, q_dequeue=0, busy=0.
- dbg_data is combinational and reflects a write on the cycle after the write edge.

Optional Feature:
- Macro: IEU_MUL_EN.
- Defined: opcode 110 runs the multi-cycle shift-add multiply as above.
- Undefined:
  - The MUL state and datapath are not built.
  - Opcode 110 is treated as NOP: no register write, retire_cnt++, ->FETCH in 2 cycles.
  - busy is never high for more than one cycle per instruction.

Test Plan:
- Load queue with 0xA45 (LDI r1,5) then 0xA87 (LDI r2,7), run=1 -> dbg r1=0x05, r2=0x07; retire_cnt=2; q_dequeue pulses exactly twice, 2 cycles apart.
- Follow with 0x2CA (ADD r3=r1+r2) and 0x54A (SUB r5=r1-r2) -> r3=0x0C, r5=0xFE; retire_cnt=4.
- 0xD0A (MUL r4=r1*r2) with IEU_MUL_EN -> busy high for 9 consecutive cycles (EXEC + 8 MUL); r4=0x23 after 10 cycles. Without the macro -> r4 unchanged (0), retire_cnt still increments.
- 0xA3F (LDI r0,63) -> dbg r0=0x00; retire_cnt increments.
- q_empty=1 for 5 cycles, then one word; toggle run low during the MUL -> no q_dequeue while empty or while run=0. The in-flight MUL completes.
- Feed 0xE00 followed by 0xA45 -> halted=1 and the second word is never popped. Assert rst_n low mid-MUL -> all regs=0, retire_cnt=0, state FETCH, no writeback.
